// File: rtl/alien_march_pkg.sv
// Shared types, widths and helpers for the alien formation march controller.
package alien_march_pkg;

  localparam int unsigned OFFSET_W = 11;
  localparam int unsigned ALIVE_W  = 6;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    StMoveR,
    StMoveL,
    StHaltLanded,
    StHaltCleared
  } march_state_t;

  // Ticks between steps: 55 alive -> 14, 1..3 alive -> 1.
  function automatic logic [CNT_W-1:0] interval_f(input logic [ALIVE_W-1:0] alive_count);
    logic [ALIVE_W-1:0] quarter;
    quarter = alive_count >> 2;
    return CNT_W'(quarter) + CNT_W'(1);
  endfunction

endpackage

// File: rtl/step_interval_timer.sv
// Counts divider ticks and strobes step once the current interval has elapsed.
module step_interval_timer
  import alien_march_pkg::*;
(
  input  logic             clk,
  input  logic             resetN,
  input  logic             tick,
  input  logic             enable,
  input  logic             restart,
  input  logic [CNT_W-1:0] interval,
  input  logic             run,
  output logic             step
);

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             adv;

  assign adv  = run && tick && enable;
  // >= rather than == so a shrinking interval never strands the counter above it.
  assign step = adv && !restart && (tick_cnt_q >= (interval - CNT_W'(1)));

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (restart) begin
      tick_cnt_d = '0;
    end else if (step) begin
      tick_cnt_d = '0;
    end else if (adv) begin
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/alien_march_ctrl.sv
// Alien formation march FSM: steps, edge drops, landing and cleared detection.
module alien_march_ctrl
  import alien_march_pkg::*;
#(
  parameter int unsigned X_START     = 160,
  parameter int unsigned Y_START     = 32,
  parameter int unsigned LEFT_LIMIT  = 16,
  parameter int unsigned RIGHT_LIMIT = 304,
  parameter int unsigned X_STEP      = 4,
  parameter int unsigned Y_STEP      = 8,
  parameter int unsigned Y_LAND      = 400
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                tick,
  input  logic                enable,
  input  logic                restart,
  input  logic [ALIVE_W-1:0]  alive_count,
  output logic [OFFSET_W-1:0] offsetX,
  output logic [OFFSET_W-1:0] offsetY,
  output logic                direction,
  output logic                moveStep,
  output logic                landed
);

  localparam int unsigned CmpW = OFFSET_W + 1;
  localparam logic [CmpW-1:0] XStepC  = CmpW'(X_STEP);
  localparam logic [CmpW-1:0] YStepC  = CmpW'(Y_STEP);
  localparam logic [CmpW-1:0] LeftC   = CmpW'(LEFT_LIMIT);
  localparam logic [CmpW-1:0] RightC  = CmpW'(RIGHT_LIMIT);
  localparam logic [CmpW-1:0] YLandC  = CmpW'(Y_LAND);

  march_state_t        state_q, state_d;
  logic [OFFSET_W-1:0] offx_q, offx_d, offy_q, offy_d;
  logic                dir_q, dir_d, step_q, step_d, land_q, land_d;
  logic [CNT_W-1:0]    interval;
  logic                run, step, at_edge;
  logic [CmpW-1:0]     x_fwd, y_drop;

  assign interval = interval_f(alive_count);
  assign run      = (state_q == StMoveR) || (state_q == StMoveL);

  step_interval_timer u_timer (
    .clk      (clk),
    .resetN   (resetN),
    .tick     (tick),
    .enable   (enable),
    .restart  (restart),
    .interval (interval),
    .run      (run),
    .step     (step)
  );

  assign x_fwd   = {1'b0, offx_q} + XStepC;
  assign y_drop  = {1'b0, offy_q} + YStepC;
  assign at_edge = (state_q == StMoveR) ? (x_fwd > RightC) : ({1'b0, offx_q} < (LeftC + XStepC));

  always_comb begin
    state_d = state_q;
    offx_d  = offx_q;
    offy_d  = offy_q;
    dir_d   = dir_q;
    land_d  = land_q;
    step_d  = 1'b0;
    if (restart) begin
      state_d = StMoveR;
      offx_d  = OFFSET_W'(X_START);
      offy_d  = OFFSET_W'(Y_START);
      dir_d   = 1'b1;
      land_d  = 1'b0;
    end else begin
      unique case (state_q)
        StMoveR, StMoveL: begin
          if (step) begin
            step_d = 1'b1;
            if (at_edge) begin
              offy_d  = y_drop[OFFSET_W-1:0];
              dir_d   = (state_q == StMoveL);
              state_d = (state_q == StMoveR) ? StMoveL : StMoveR;
              if (y_drop >= YLandC) begin
                state_d = StHaltLanded;
                land_d  = 1'b1;
              end
            end else if (state_q == StMoveR) begin
              offx_d = x_fwd[OFFSET_W-1:0];
            end else begin
              offx_d = offx_q - OFFSET_W'(X_STEP);
            end
          end else if (enable && (alive_count == '0)) begin
            state_d = StHaltCleared;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StMoveR;
      offx_q  <= OFFSET_W'(X_START);
      offy_q  <= OFFSET_W'(Y_START);
      dir_q   <= 1'b1;
      step_q  <= 1'b0;
      land_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      offx_q  <= offx_d;
      offy_q  <= offy_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      land_q  <= land_d;
    end
  end

  assign offsetX   = offx_q;
  assign offsetY   = offy_q;
  assign direction = dir_q;
  assign moveStep  = step_q;
  assign landed    = land_q;

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Directed plus randomized checks of alien_march_ctrl against an integer reference model.
module tb_alien_march_ctrl;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        tick = 1'b0;
  logic        enable = 1'b0;
  logic        restart = 1'b0;
  logic [5:0]  alive_count = 6'd55;
  logic [10:0] offsetX, offsetY;
  logic        direction, moveStep, landed;

  int nvec = 0;
  int nerr = 0;

  // Reference model: positions as plain integers, phase 0 = marching, 1 = landed, 2 = cleared.
  int mx, my, mdir, mstep, mland, mphase, mticks;

  always #5 clk = ~clk;

  alien_march_ctrl dut (
    .clk         (clk),
    .resetN      (resetN),
    .tick        (tick),
    .enable      (enable),
    .restart     (restart),
    .alive_count (alive_count),
    .offsetX     (offsetX),
    .offsetY     (offsetY),
    .direction   (direction),
    .moveStep    (moveStep),
    .landed      (landed)
  );

  task automatic model_reset();
    mx = 160; my = 32; mdir = 1; mstep = 0; mland = 0; mphase = 0; mticks = 0;
  endtask

  task automatic model_drop();
    my   = my + 8;
    mdir = 1 - mdir;
    if (my >= 400) begin
      mland  = 1;
      mphase = 1;
    end
  endtask

  // One clock edge of the game rules, using the inputs sampled at that edge.
  task automatic model_edge();
    mstep = 0;
    if (restart) begin
      model_reset();
    end else if (mphase == 0 && enable) begin
      if (tick) begin
        mticks = mticks + 1;
        if (mticks >= (alive_count / 4) + 1) begin
          mticks = 0;
          mstep  = 1;
          if (mdir == 1) begin
            if (mx + 4 > 304) model_drop();
            else mx = mx + 4;
          end else begin
            if (mx - 4 < 16) model_drop();
            else mx = mx - 4;
          end
        end
      end else if (alive_count == 0) begin
        mphase = 2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("offsetX", 32'(offsetX), mx);
    chk("offsetY", 32'(offsetY), my);
    chk("direction", 32'(direction), mdir);
    chk("moveStep", 32'(moveStep), mstep);
    chk("landed", 32'(landed), mland);
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // One divider period: tick on the first of three clocks; reports moveStep after the tick edge.
  task automatic pulse_tick(output logic stepped);
    tick = 1'b1;
    clk_cycle();
    stepped = moveStep;
    tick = 1'b0;
    clk_cycle();
    clk_cycle();
  endtask

  logic s;
  int   n;

  initial begin
    model_reset();
    #12;
    check_all();
    resetN = 1'b1;
    enable = 1'b1;

    // 55 alive: first step on the 14th tick.
    alive_count = 6'd55;
    for (int i = 1; i <= 13; i++) begin
      pulse_tick(s);
      chk("no_early_step", 32'(s), 0);
    end
    pulse_tick(s);
    chk("step_on_14th", 32'(s), 1);
    chk("first_step_x", 32'(offsetX), 164);
    chk("first_step_dir", 32'(direction), 1);

    // Interval 1: march to the right edge, then drop.
    alive_count = 6'd3;
    n = 0;
    while (mx != 304 && n < 100) begin
      pulse_tick(s);
      n++;
    end
    chk("reach_right_edge", 32'(offsetX), 304);
    pulse_tick(s);
    chk("edge_x_held", 32'(offsetX), 304);
    chk("edge_y_drop", 32'(offsetY), 40);
    chk("edge_dir_left", 32'(direction), 0);
    pulse_tick(s);
    chk("moves_left", 32'(offsetX), 300);

    // Interval shrinks below tick count: 55 alive, 10 ticks, then 4 alive.
    restart = 1'b1; clk_cycle(); restart = 1'b0;
    alive_count = 6'd55;
    for (int i = 0; i < 10; i++) pulse_tick(s);
    alive_count = 6'd4;
    pulse_tick(s);
    chk("shrink_step", 32'(s), 1);
    pulse_tick(s);
    chk("shrink_cnt_cleared", 32'(s), 0);
    pulse_tick(s);
    chk("shrink_interval2", 32'(s), 1);

    // restart coincident with a stepping tick.
    alive_count = 6'd3;
    tick = 1'b1; restart = 1'b1;
    clk_cycle();
    tick = 1'b0; restart = 1'b0;
    chk("restart_x", 32'(offsetX), 160);
    chk("restart_step", 32'(moveStep), 0);
    clk_cycle(); clk_cycle();

    // enable low for 20 ticks: nothing moves.
    pulse_tick(s);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) pulse_tick(s);
    chk("hold_x", 32'(offsetX), 164);
    enable = 1'b1;

    // Randomized ticks, enable, alive count and occasional restart.
    for (int i = 0; i < 300; i++) begin
      alive_count = 6'($urandom_range(1, 55));
      enable      = ($urandom_range(0, 3) != 0);
      restart     = ($urandom_range(0, 39) == 0);
      tick        = ($urandom_range(0, 4) != 0);
      clk_cycle();
      restart = 1'b0;
      tick    = 1'b0;
      clk_cycle();
      clk_cycle();
    end
    enable = 1'b1;

    // Cleared: alive 0 on an idle cycle halts; ticks are then ignored.
    alive_count = 6'd0;
    clk_cycle();
    for (int i = 0; i < 5; i++) begin
      pulse_tick(s);
      chk("cleared_no_step", 32'(s), 0);
    end
    restart = 1'b1; clk_cycle(); restart = 1'b0;
    chk("cleared_restart_x", 32'(offsetX), 160);
    chk("cleared_restart_y", 32'(offsetY), 32);

    // Landing: march down to y = 400, bounded tick budget.
    alive_count = 6'd3;
    n = 0;
    while (mland == 0 && n < 5000) begin
      pulse_tick(s);
      n++;
    end
    chk("landed_flag", 32'(landed), 1);
    chk("landed_y", 32'(offsetY), 400);
    for (int i = 0; i < 5; i++) begin
      pulse_tick(s);
      chk("landed_no_step", 32'(s), 0);
    end

    // Asynchronous reset in the middle of a step cycle.
    restart = 1'b1; clk_cycle(); restart = 1'b0;
    tick = 1'b1; clk_cycle(); tick = 1'b0;
    chk("pre_reset_step", 32'(moveStep), 1);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    chk("async_reset_x", 32'(offsetX), 160);
    chk("async_reset_step", 32'(moveStep), 0);
    @(negedge clk);
    resetN = 1'b1;
    clk_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
